// File: rtl/pc_ras.sv
// pc_ras: fetch program counter with a small circular return-address stack.
// The PC register takes redirects from debug reset, exceptions, the debugger
// and resolved branches; otherwise it advances by 4, or jumps to a predicted
// return target popped from the stack when the fetch is a "jr $ra".
module pc_ras #(
  parameter int                ADDR_W       = 32,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [ADDR_W-1:0] ALIGN_MASK   = {{(ADDR_W-2){1'b1}}, 2'b00}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pc_enable,
  input  logic                          do_branch,
  input  logic [ADDR_W-1:0]             branch_addr,
  input  logic                          do_exception,
  input  logic [ADDR_W-1:0]             exception_addr,
  input  logic                          do_debug,
  input  logic [ADDR_W-1:0]             debug_addr,
  input  logic                          debug_reset,
  input  logic                          ras_push,
  input  logic                          ras_pop,
  output logic [ADDR_W-1:0]             pc_addr,
  output logic                          pred_taken,
  output logic [$clog2(RAS_DEPTH):0]    ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  // Stack storage; r_sp points at the next free slot, the top is r_sp-1.
  logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]     r_sp;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pred;

  logic              w_ops_ok;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_top_idx;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_ret;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [PW-1:0]     w_sp_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic              w_pred_nxt;
  logic              w_wr_en;
  logic [PW-1:0]     w_wr_idx;

  // Stack ops only happen on a plain advancing fetch with no redirect pending.
  assign w_ops_ok  = pc_enable & ~do_branch & ~do_exception & ~do_debug & ~debug_reset;
  assign w_push    = w_ops_ok & ras_push;
  assign w_pop     = w_ops_ok & ras_pop & (r_count != '0);
  assign w_top_idx = r_sp - PW'(1);
  assign w_top     = r_stack[w_top_idx];
  assign w_seq     = r_pc + ADDR_W'(4);
  assign w_ret     = r_pc + ADDR_W'(8);

  // Next-state selection in priority order; default is a full hold (stall).
  always_comb begin
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_count_nxt = r_count;
    w_pred_nxt  = r_pred;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_sp;
    if (debug_reset) begin
      w_pc_nxt    = RESET_VECTOR;
      w_sp_nxt    = '0;
      w_count_nxt = '0;
      w_pred_nxt  = 1'b0;
    end else if (do_exception) begin
      w_pc_nxt    = exception_addr & ALIGN_MASK;
      w_sp_nxt    = '0;
      w_count_nxt = '0;
      w_pred_nxt  = 1'b0;
    end else if (do_debug) begin
      w_pc_nxt   = debug_addr;
      w_pred_nxt = 1'b0;
    end else if (pc_enable) begin
      w_pred_nxt = 1'b0;
      if (do_branch) begin
        w_pc_nxt = branch_addr & ALIGN_MASK;
      end else begin
        if (w_pop) begin
          w_pc_nxt   = w_top & ALIGN_MASK;
          w_pred_nxt = 1'b1;
        end else begin
          w_pc_nxt = w_seq;
        end
        if (w_push && w_pop) begin
          // Return to the old top and reuse its slot for the new call.
          w_wr_en  = 1'b1;
          w_wr_idx = w_top_idx;
        end else if (w_push) begin
          // When full the pointer wraps onto the oldest entry.
          w_wr_en     = 1'b1;
          w_wr_idx    = r_sp;
          w_sp_nxt    = r_sp + PW'(1);
          w_count_nxt = (r_count == FULL) ? FULL : r_count + CW'(1);
        end else if (w_pop) begin
          w_sp_nxt    = w_top_idx;
          w_count_nxt = r_count - CW'(1);
        end
      end
    end
  end

  // Control and PC registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_sp    <= '0;
      r_count <= '0;
      r_pred  <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_count <= w_count_nxt;
      r_pred  <= w_pred_nxt;
    end
  end

  // Stack entries carry no reset; the count says which are meaningful.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_stack[w_wr_idx] <= w_ret;
  end

  assign pc_addr    = r_pc;
  assign pred_taken = r_pred;
  assign ras_count  = r_count;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras: reset, sequential fetch, stack push/pop,
// overflow, redirect priority, stalls, wrap and asynchronous reset.
module tb_pc_ras;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_enable, do_branch, do_exception, do_debug, debug_reset;
  logic        ras_push, ras_pop;
  logic [31:0] branch_addr, exception_addr, debug_addr;
  logic [31:0] pc_addr;
  logic        pred_taken;
  logic [2:0]  ras_count;

  int n_tests = 0;
  int n_fail  = 0;

  pc_ras dut (
    .clk(clk), .rst_n(rst_n), .pc_enable(pc_enable),
    .do_branch(do_branch), .branch_addr(branch_addr),
    .do_exception(do_exception), .exception_addr(exception_addr),
    .do_debug(do_debug), .debug_addr(debug_addr), .debug_reset(debug_reset),
    .ras_push(ras_push), .ras_pop(ras_pop),
    .pc_addr(pc_addr), .pred_taken(pred_taken), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [31:0] pc, input logic pr, input logic [2:0] cnt);
    chk({tag, ".pc"}, pc_addr, pc);
    chk({tag, ".pred"}, {31'd0, pred_taken}, {31'd0, pr});
    chk({tag, ".cnt"}, {29'd0, ras_count}, {29'd0, cnt});
  endtask

  initial begin
    rst_n = 1'b0; pc_enable = 0; do_branch = 0; do_exception = 0; do_debug = 0;
    debug_reset = 0; ras_push = 0; ras_pop = 0;
    branch_addr = '0; exception_addr = '0; debug_addr = '0;
    step(); step();
    chk3("reset", 32'hBFC00000, 1'b0, 3'd0);
    rst_n = 1'b1;

    // Sequential fetch after reset
    pc_enable = 1;
    step(); chk("seq1", pc_addr, 32'hBFC00004);
    step(); chk("seq2", pc_addr, 32'hBFC00008);
    step(); chk("seq3", pc_addr, 32'hBFC0000C);

    // Single push then pop at a later pc
    do_debug = 1; debug_addr = 32'h80000010;
    step(); chk3("dbg_load", 32'h80000010, 1'b0, 3'd0);
    do_debug = 0; ras_push = 1;
    step(); chk3("push1", 32'h80000014, 1'b0, 3'd1);
    ras_push = 0;
    step(); step(); chk("adv", pc_addr, 32'h8000001C);
    ras_pop = 1;
    step(); chk3("pop1", 32'h80000018, 1'b1, 3'd0);
    ras_pop = 0;
    step(); chk3("after_pop1", 32'h8000001C, 1'b0, 3'd0);

    // Overflow: five pushes into a four-deep stack, then five pops
    do_debug = 1; debug_addr = 32'h80001000;
    step();
    do_debug = 0; ras_push = 1;
    step(); chk("ovf_c1", {29'd0, ras_count}, 32'd1);
    step(); chk("ovf_c2", {29'd0, ras_count}, 32'd2);
    step(); chk("ovf_c3", {29'd0, ras_count}, 32'd3);
    step(); chk("ovf_c4", {29'd0, ras_count}, 32'd4);
    step(); chk3("ovf_c5", 32'h80001014, 1'b0, 3'd4);
    ras_push = 0; ras_pop = 1;
    step(); chk3("opop1", 32'h80001018, 1'b1, 3'd3);
    step(); chk3("opop2", 32'h80001014, 1'b1, 3'd2);
    step(); chk3("opop3", 32'h80001010, 1'b1, 3'd1);
    step(); chk3("opop4", 32'h8000100C, 1'b1, 3'd0);
    step(); chk3("opop5_empty", 32'h80001010, 1'b0, 3'd0);

    // Push+pop with empty stack acts as push; with entries, swaps top
    ras_push = 1; ras_pop = 1;
    step(); chk3("pp_empty", 32'h80001014, 1'b0, 3'd1);
    step(); chk3("pp_swap", 32'h80001018, 1'b1, 3'd1);
    ras_push = 0;
    step(); chk3("pp_pop", 32'h8000101C, 1'b1, 3'd0);

    // Exception beats branch and pop, clears the stack
    ras_pop = 0; ras_push = 1;
    step(); chk3("pre_exc", 32'h80001020, 1'b0, 3'd1);
    ras_push = 0; ras_pop = 1; do_exception = 1; exception_addr = 32'h80000183;
    do_branch = 1; branch_addr = 32'h12345678;
    step(); chk3("exc", 32'h80000180, 1'b0, 3'd0);

    // Branch is masked and leaves the stack intact, ignoring pop
    do_exception = 0; do_branch = 0; ras_pop = 0; ras_push = 1;
    step(); chk3("push_b", 32'h80000184, 1'b0, 3'd1);
    ras_push = 0; ras_pop = 1; do_branch = 1; branch_addr = 32'h80002003;
    step(); chk3("branch", 32'h80002000, 1'b0, 3'd1);
    do_branch = 0;
    step(); chk3("pop_b", 32'h80000188, 1'b1, 3'd0);

    // Stall with push requested: everything holds
    ras_pop = 0; ras_push = 1; pc_enable = 0;
    for (int i = 0; i < 4; i++) begin
      step(); chk3($sformatf("stall%0d", i), 32'h80000188, 1'b1, 3'd0);
    end
    ras_push = 0; do_debug = 1; debug_addr = 32'h00000001;
    step(); chk3("dbg_unmasked", 32'h00000001, 1'b0, 3'd0);

    // Debug reset beats exception and clears stack
    do_debug = 0; pc_enable = 1; ras_push = 1;
    step(); chk3("push_d", 32'h00000005, 1'b0, 3'd1);
    ras_push = 0; debug_reset = 1; do_exception = 1; exception_addr = 32'h80000180;
    step(); chk3("dbg_reset", 32'hBFC00000, 1'b0, 3'd0);

    // Address wrap
    debug_reset = 0; do_exception = 0; do_debug = 1; debug_addr = 32'hFFFFFFFC;
    step();
    do_debug = 0;
    step(); chk3("wrap", 32'h00000000, 1'b0, 3'd0);
    ras_push = 1;
    step(); chk3("push_w", 32'h00000004, 1'b0, 3'd1);

    // Asynchronous reset between edges, with a redirect held on inputs
    ras_push = 0; do_branch = 1; branch_addr = 32'h80004000;
    #2 rst_n = 1'b0;
    #1 chk3("async_rst", 32'hBFC00000, 1'b0, 3'd0);
    step(); chk3("rst_hold", 32'hBFC00000, 1'b0, 3'd0);
    do_branch = 0; rst_n = 1'b1;
    step(); chk("rst_release", pc_addr, 32'hBFC00004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
